// File: rtl/fetch_pc_unit_pkg.sv
// Shared types and constants for the fetch PC unit.
package fetch_pkg;
    localparam int ADDR_W     = 7;
    localparam int INSTR_STEP = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] imm;
    } instr_fields_t;
endpackage

// File: rtl/fetch_pc_unit_if.sv
// IF/ID handshake bus between fetch (master) and decode (slave).
interface fetch_pc_unit_if #(parameter int ADDR_W = fetch_pkg::ADDR_W);
    logic              id_valid;
    logic              id_ready;
    logic [ADDR_W-1:0] id_pc;
    logic [4:0]        id_rd;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic [11:0]       id_imm;

    modport master (output id_valid, id_pc, id_rd, id_rs1, id_rs2, id_imm,
                    input  id_ready);
    modport slave  (input  id_valid, id_pc, id_rd, id_rs1, id_rs2, id_imm,
                    output id_ready);
endinterface

// File: rtl/fetch_pc_unit_if_id_reg.sv
// IF/ID holding register: load a new entry, flush it, or hold until accepted.
module if_id_reg #(
    parameter int ADDR_W = fetch_pkg::ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    flush,
    input  logic                    ready,
    input  logic [ADDR_W-1:0]       pc_in,
    input  fetch_pkg::instr_fields_t fields_in,
    output logic                    valid,
    output logic [ADDR_W-1:0]       pc,
    output fetch_pkg::instr_fields_t fields
);
    import fetch_pkg::*;

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    instr_fields_t     fields_q, fields_d;

    // Flush wins over load; an accepted entry with no replacement empties the slot.
    always_comb begin
        valid_d  = valid_q;
        pc_d     = pc_q;
        fields_d = fields_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d  = 1'b1;
            pc_d     = pc_in;
            fields_d = fields_in;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    // Register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            pc_q     <= '0;
            fields_q <= '0;
        end else begin
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            fields_q <= fields_d;
        end
    end

    assign valid  = valid_q;
    assign pc     = pc_q;
    assign fields = fields_q;
endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: owns the PC, captures memory fields into IF/ID, handles
// stalls, redirects and halt on an all-zero word.
module fetch_pc_unit #(
    parameter int                ADDR_W       = fetch_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0,
    parameter bit                HALT_ON_ZERO = 1'b1,
    parameter int                CNT_W        = 16
) (
    input  logic                clk,
    input  logic                rst,
    output logic [ADDR_W-1:0]   pc_out,
    input  logic [4:0]          mem_rd,
    input  logic [4:0]          mem_rs1,
    input  logic [4:0]          mem_rs2,
    input  logic [11:0]         mem_imm,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_tgt,
    fetch_pc_unit_if.master     id_if,
    output logic                halted,
    output logic [CNT_W-1:0]    fetch_count
);
    import fetch_pkg::*;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              capture, flush, xfer, slot_open, zero_word;
    instr_fields_t     mem_fields, id_fields;

    assign mem_fields = '{rd: mem_rd, rs1: mem_rs1, rs2: mem_rs2, imm: mem_imm};
    assign zero_word  = HALT_ON_ZERO && (mem_fields == '0);
    assign xfer       = id_if.id_valid && id_if.id_ready;
    assign slot_open  = !id_if.id_valid || id_if.id_ready;

    // Next-state, PC and capture decisions; redirect overrides every state.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        capture = 1'b0;
        flush   = 1'b0;
        if (redirect_valid) begin
            pc_d    = redirect_tgt & ~ADDR_W'(3);
            flush   = 1'b1;
            state_d = RUN;
        end else begin
            case (state_q)
                IDLE: state_d = RUN;
                RUN: begin
                    if (slot_open) begin
                        if (zero_word) begin
                            state_d = HALTED;
                        end else begin
                            capture = 1'b1;
                            pc_d    = pc_q + ADDR_W'(INSTR_STEP);
                        end
                    end
                end
                HALTED:  state_d = HALTED;
                default: state_d = IDLE;
            endcase
        end
        cnt_d = cnt_q + CNT_W'(xfer);
    end

    // State, PC and transfer counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    if_id_reg #(.ADDR_W(ADDR_W)) u_if_id (
        .clk       (clk),
        .rst       (rst),
        .load      (capture),
        .flush     (flush),
        .ready     (id_if.id_ready),
        .pc_in     (pc_q),
        .fields_in (mem_fields),
        .valid     (id_if.id_valid),
        .pc        (id_if.id_pc),
        .fields    (id_fields)
    );

    assign id_if.id_rd  = id_fields.rd;
    assign id_if.id_rs1 = id_fields.rs1;
    assign id_if.id_rs2 = id_fields.rs2;
    assign id_if.id_imm = id_fields.imm;
    assign pc_out       = pc_q;
    assign halted       = (state_q == HALTED);
    assign fetch_count  = cnt_q;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with a transfer scoreboard.
module tb_fetch_pc_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  pc_out;
    logic [4:0]  mem_rd, mem_rs1, mem_rs2;
    logic [11:0] mem_imm;
    logic        redirect_valid;
    logic [6:0]  redirect_tgt;
    logic        halted;
    logic [15:0] fetch_count;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [6:0]    pc;
        instr_fields_t f;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;

    fetch_pc_unit_if #(.ADDR_W(7)) id_if();

    fetch_pc_unit #(.ADDR_W(7), .RESET_PC(7'h00), .HALT_ON_ZERO(1'b1), .CNT_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_out         (pc_out),
        .mem_rd         (mem_rd),
        .mem_rs1        (mem_rs1),
        .mem_rs2        (mem_rs2),
        .mem_imm        (mem_imm),
        .redirect_valid (redirect_valid),
        .redirect_tgt   (redirect_tgt),
        .id_if          (id_if),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    // Instruction memory image: word at 76 is all zero, everything else nonzero.
    function automatic instr_fields_t mem(input logic [6:0] a);
        instr_fields_t f;
        if (a == 7'd76) begin
            f = '0;
        end else begin
            f.rd  = a[6:2] + 5'd13;
            f.rs1 = a[6:2];
            f.rs2 = 5'd1;
            f.imm = {5'h01, a};
        end
        return f;
    endfunction

    instr_fields_t mf;
    assign mf      = mem(pc_out);
    assign mem_rd  = mf.rd;
    assign mem_rs1 = mf.rs1;
    assign mem_rs2 = mf.rs2;
    assign mem_imm = mf.imm;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [6:0] pc);
        exp_q.push_back({pc, mem(pc)});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted IF/ID transfer must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && id_if.id_valid && id_if.id_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL xfer_unexpected: got id_pc=0x%0h expected no transfer", id_if.id_pc);
            end else begin
                e = exp_q.pop_front();
                chk("xfer_pc", 32'(id_if.id_pc), 32'(e.pc));
                chk("xfer_fields", 32'({id_if.id_rd, id_if.id_rs1, id_if.id_rs2, id_if.id_imm}), 32'(e.f));
            end
        end
    end

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_tgt = '0; id_if.id_ready = 1'b1;
        step(); step();
        chk("rst_pc", 32'(pc_out), 0);
        chk("rst_valid", 32'(id_if.id_valid), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_count", 32'(fetch_count), 0);
        chk("rst_id_pc", 32'(id_if.id_pc), 0);

        // 1: release reset, one IDLE bubble then streaming
        rst = 1'b0;
        push(7'd0); push(7'd4); push(7'd8);
        step();
        chk("idle_pc", 32'(pc_out), 0);
        chk("idle_valid", 32'(id_if.id_valid), 0);
        step();
        chk("run_pc4", 32'(pc_out), 4);
        chk("run_valid", 32'(id_if.id_valid), 1);
        chk("run_id_pc0", 32'(id_if.id_pc), 0);
        chk("run_id_rd13", 32'(id_if.id_rd), 13);
        step();
        chk("run_pc8", 32'(pc_out), 8);
        chk("run_id_pc4", 32'(id_if.id_pc), 4);
        step();
        chk("run_pc12", 32'(pc_out), 12);
        chk("run_id_pc8", 32'(id_if.id_pc), 8);
        chk("run_count2", 32'(fetch_count), 2);

        // 2: stall three cycles holding id_pc=8
        id_if.id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_valid", 32'(id_if.id_valid), 1);
            chk("stall_id_pc", 32'(id_if.id_pc), 8);
            chk("stall_fields", 32'({id_if.id_rd, id_if.id_rs1, id_if.id_rs2, id_if.id_imm}), 32'(mem(7'd8)));
            chk("stall_pc", 32'(pc_out), 12);
            chk("stall_count", 32'(fetch_count), 2);
        end
        id_if.id_ready = 1'b1;
        step();
        chk("unstall_id_pc", 32'(id_if.id_pc), 12);
        chk("unstall_pc", 32'(pc_out), 16);
        chk("unstall_count", 32'(fetch_count), 3);

        // 3: redirect to 0x23 while stalled; entry 12 is flushed unsent
        id_if.id_ready = 1'b0;
        redirect_valid = 1'b1; redirect_tgt = 7'h23;
        step();
        chk("redir_pc", 32'(pc_out), 32'h20);
        chk("redir_valid", 32'(id_if.id_valid), 0);
        chk("redir_count", 32'(fetch_count), 3);
        redirect_valid = 1'b0; id_if.id_ready = 1'b1;
        for (int a = 32; a <= 72; a += 4) push(7'(a));
        step();
        chk("redir_id_pc", 32'(id_if.id_pc), 32'h20);
        chk("redir_next_pc", 32'(pc_out), 32'h24);

        // 4: run into the zero word at 76
        for (int k = 0; k < 40 && !halted; k++) step();
        chk("halt_reached", 32'(halted), 1);
        chk("halt_pc", 32'(pc_out), 76);
        chk("halt_drained", 32'(id_if.id_valid), 0);
        chk("halt_count", 32'(fetch_count), 14);
        step(); step();
        chk("halt_pc_frozen", 32'(pc_out), 76);
        chk("halt_stays", 32'(halted), 1);
        chk("halt_no_capture", 32'(id_if.id_valid), 0);
        redirect_valid = 1'b1; redirect_tgt = 7'h00;
        step();
        chk("resume_halted", 32'(halted), 0);
        chk("resume_pc", 32'(pc_out), 0);
        redirect_valid = 1'b0;
        push(7'd0);
        step();
        chk("resume_id_pc", 32'(id_if.id_pc), 0);
        chk("resume_next_pc", 32'(pc_out), 4);

        // 5: redirect to 124 with a same-cycle transfer, then wrap to 0
        redirect_valid = 1'b1; redirect_tgt = 7'd124;
        step();
        chk("wrap_redir_pc", 32'(pc_out), 124);
        chk("wrap_redir_valid", 32'(id_if.id_valid), 0);
        chk("wrap_redir_count", 32'(fetch_count), 15);
        redirect_valid = 1'b0;
        push(7'd124);
        step();
        chk("wrap_id_pc124", 32'(id_if.id_pc), 124);
        chk("wrap_pc0", 32'(pc_out), 0);
        step();
        chk("wrap_id_pc0", 32'(id_if.id_pc), 0);
        chk("wrap_pc4", 32'(pc_out), 4);
        chk("wrap_count", 32'(fetch_count), 16);

        // 6: reset while an entry is held unaccepted
        id_if.id_ready = 1'b0;
        step();
        chk("prerst_valid", 32'(id_if.id_valid), 1);
        chk("prerst_pc", 32'(pc_out), 4);
        rst = 1'b1;
        step();
        chk("midrst_valid", 32'(id_if.id_valid), 0);
        chk("midrst_pc", 32'(pc_out), 0);
        chk("midrst_count", 32'(fetch_count), 0);
        chk("midrst_halted", 32'(halted), 0);
        rst = 1'b0;
        step();

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
